// File: rtl/alu_seq.sv
// Multi-cycle ALU with a Start/Busy/Done handshake and registered N/C/V/Z flags.
// Optional macro ALU_MUL_EN builds the WIDTH-iteration shift-add multiply for code 11.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [3:0]       Function,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  output logic [WIDTH-1:0] Result,
  output logic             Zflag,
  output logic             Nflag,
  output logic             Cflag,
  output logic             Vflag,
  output logic             Busy,
  output logic             Done,
  output logic             dbg_state
);
  // Handshake: Start is accepted on a rising edge only while Busy=0; Done pulses
  // for one cycle when Result/flags are updated. Start during Busy is dropped.
  localparam int CW = SHW + 1;

  localparam logic [3:0] F_MEM  = 4'd0;
  localparam logic [3:0] F_ADD  = 4'd1;
  localparam logic [3:0] F_SUB  = 4'd2;
  localparam logic [3:0] F_AND  = 4'd3;
  localparam logic [3:0] F_OR   = 4'd4;
  localparam logic [3:0] F_NOT  = 4'd5;
  localparam logic [3:0] F_LSL1 = 4'd6;
  localparam logic [3:0] F_LSR1 = 4'd7;
  localparam logic [3:0] F_ASR1 = 4'd8;
  localparam logic [3:0] F_LSLN = 4'd9;
  localparam logic [3:0] F_LSRN = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] F_MUL  = 4'd11;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       func_q, func_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic             done_q, done_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0]   mul_sum;
`endif

  logic [WIDTH:0]   add_w, sub_w;
  logic [CW-1:0]    n_amt;
  logic             ld, ld_c, ld_v;
  logic [WIDTH-1:0] ld_r;

  assign add_w = {1'b0, Op1} + {1'b0, Op2};
  assign sub_w = {1'b0, Op1} - {1'b0, Op2};
  assign n_amt = {1'b0, Op2[SHW-1:0]};

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    done_d   = 1'b0;
    ld       = 1'b0;
    ld_r     = '0;
    ld_c     = 1'b0;
    ld_v     = 1'b0;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    mul_sum  = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          func_d = Function;
          case (Function)
            F_ADD: begin
              ld   = 1'b1;
              ld_r = add_w[WIDTH-1:0];
              ld_c = add_w[WIDTH];
              ld_v = (Op1[WIDTH-1] == Op2[WIDTH-1]) && (add_w[WIDTH-1] != Op1[WIDTH-1]);
            end
            F_SUB: begin
              ld   = 1'b1;
              ld_r = sub_w[WIDTH-1:0];
              ld_c = sub_w[WIDTH];
              ld_v = (Op1[WIDTH-1] != Op2[WIDTH-1]) && (sub_w[WIDTH-1] != Op1[WIDTH-1]);
            end
            F_AND:  begin ld = 1'b1; ld_r = Op1 & Op2; end
            F_OR:   begin ld = 1'b1; ld_r = Op1 | Op2; end
            F_NOT:  begin ld = 1'b1; ld_r = ~Op1; end
            F_LSL1: begin ld = 1'b1; ld_r = {Op1[WIDTH-2:0], 1'b0}; ld_c = Op1[WIDTH-1]; end
            F_LSR1: begin ld = 1'b1; ld_r = {1'b0, Op1[WIDTH-1:1]}; ld_c = Op1[0]; end
            F_ASR1: begin ld = 1'b1; ld_r = {Op1[WIDTH-1], Op1[WIDTH-1:1]}; ld_c = Op1[0]; end
            F_LSLN, F_LSRN: begin
              if (n_amt == '0) begin
                ld   = 1'b1;
                ld_r = Op1;
              end else begin
                work_d  = Op1;
                cnt_d   = n_amt;
                state_d = S_RUN;
              end
            end
`ifdef ALU_MUL_EN
            F_MUL: begin
              work_d  = Op2;
              mcand_d = Op1;
              hi_d    = '0;
              cnt_d   = CW'(WIDTH);
              state_d = S_RUN;
            end
`endif
            default: begin ld = 1'b1; ld_r = Op1; end
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        case (func_q)
          F_LSLN: begin work_d = {work_q[WIDTH-2:0], 1'b0}; ld_c = work_q[WIDTH-1]; end
          F_LSRN: begin work_d = {1'b0, work_q[WIDTH-1:1]}; ld_c = work_q[0]; end
`ifdef ALU_MUL_EN
          // Multiplier sits in work_q and shifts out as product bits shift in.
          F_MUL: begin
            mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
            hi_d    = mul_sum[WIDTH:1];
            work_d  = {mul_sum[0], work_q[WIDTH-1:1]};
            ld_c    = |mul_sum[WIDTH:1];
          end
`endif
          default: ;
        endcase
        if (cnt_q == CW'(1)) begin
          ld      = 1'b1;
          ld_r    = work_d;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ld) begin
      result_d = ld_r;
      z_d      = (ld_r == '0);
      n_d      = ld_r[WIDTH-1];
      c_d      = ld_c;
      v_d      = ld_v;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      func_q   <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      done_q   <= done_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
`endif
    end
  end

  assign Result    = result_q;
  assign Zflag     = z_q;
  assign Nflag     = n_q;
  assign Cflag     = c_q;
  assign Vflag     = v_q;
  assign Busy      = (state_q == S_RUN);
  assign Done      = done_q;
  assign dbg_state = (state_q == S_RUN);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: driver pushes expected {latency, result, ZNCV}
// into a queue; a monitor pops and compares on every Done pulse.
module tb_alu_seq;
  localparam int W  = 16;
  localparam int EW = 8 + W + 4;

  logic         Clock = 1'b0;
  logic         nReset;
  logic         Start;
  logic [3:0]   Function;
  logic [W-1:0] Op1, Op2;
  logic [W-1:0] Result;
  logic         Zflag, Nflag, Cflag, Vflag, Busy, Done, dbg_state;

  logic [EW-1:0] exp_q[$];
  int            iss_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Function(Function),
    .Op1(Op1), .Op2(Op2), .Result(Result), .Zflag(Zflag), .Nflag(Nflag),
    .Cflag(Cflag), .Vflag(Vflag), .Busy(Busy), .Done(Done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge Clock) begin
    if (nReset === 1'b1 && Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        logic [EW-1:0] e;
        int t;
        e = exp_q.pop_front();
        t = iss_q.pop_front();
        chk("result", 32'(Result), 32'(e[W+3:4]));
        chk("flags_zncv", {28'd0, Zflag, Nflag, Cflag, Vflag}, {28'd0, e[3:0]});
        chk("latency", 32'(cyc - t), 32'(e[EW-1:W+4]));
      end
    end
  end

  // driver tasks (called just after a falling edge)
  task automatic push_exp(input logic [W-1:0] r, input logic [3:0] fl, input int lat);
    exp_q.push_back({8'(lat), r, fl});
    iss_q.push_back(cyc);
  endtask

  task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic [3:0] fl, input int lat);
    Start = 1'b1; Function = f; Op1 = a; Op2 = b;
    push_exp(r, fl, lat);
    @(negedge Clock);
    Start = 1'b0; Function = 4'hF; Op1 = '1; Op2 = '1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((Busy !== 1'b0 || exp_q.size() != 0) && n < 60) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 60) chk("wait_idle_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge Clock);
  endtask

  initial begin
    int n;
    nReset = 1'b0; Start = 1'b0; Function = '0; Op1 = '0; Op2 = '0;
    repeat (3) @(negedge Clock);
    chk("reset_result", 32'(Result), 32'd0);
    chk("reset_flags", {28'd0, Zflag, Nflag, Cflag, Vflag}, 32'd0);
    chk("reset_busy_done", {30'd0, Busy, Done}, 32'd0);
    nReset = 1'b1;
    @(negedge Clock);

    // flags are {Z,N,C,V}
    issue(4'd1,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1);  wait_idle();
    issue(4'd2,  16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1);  wait_idle();
    issue(4'd10, 16'h8001, 16'h0004, 16'h0800, 4'b0000, 5);  wait_idle();
    issue(4'd9,  16'h1234, 16'h0010, 16'h1234, 4'b0000, 1);  wait_idle();
    issue(4'd8,  16'h8002, 16'h0000, 16'hC001, 4'b0100, 1);  wait_idle();
    issue(4'd6,  16'h8000, 16'h0000, 16'h0000, 4'b1010, 1);  wait_idle();
    issue(4'd0,  16'h5A5A, 16'hFFFF, 16'h5A5A, 4'b0000, 1);  wait_idle();
    issue(4'd3,  16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1);  wait_idle();
    issue(4'd4,  16'hF0F0, 16'h0F00, 16'hFFF0, 4'b0100, 1);  wait_idle();
    issue(4'd5,  16'h00FF, 16'h0000, 16'hFF00, 4'b0100, 1);  wait_idle();
    issue(4'd7,  16'h0003, 16'h0000, 16'h0001, 4'b0010, 1);  wait_idle();
    issue(4'd1,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1);  wait_idle();
    issue(4'd2,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1);  wait_idle();
    issue(4'd9,  16'hA421, 16'h0003, 16'h2108, 4'b0010, 4);  wait_idle();
    issue(4'd10, 16'hF000, 16'h0014, 16'h0F00, 4'b0000, 5);  wait_idle();
    issue(4'd12, 16'h1357, 16'h2468, 16'h1357, 4'b0000, 1);  wait_idle();
    issue(4'd15, 16'h8642, 16'h0001, 16'h8642, 4'b0100, 1);  wait_idle();
`ifdef ALU_MUL_EN
    issue(4'd11, 16'h0123, 16'h0010, 16'h1230, 4'b0000, 17); wait_idle();
    issue(4'd11, 16'h1000, 16'h0100, 16'h0000, 4'b1010, 17); wait_idle();
    issue(4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 17); wait_idle();
`else
    issue(4'd11, 16'h0123, 16'h0010, 16'h0123, 4'b0000, 1);  wait_idle();
`endif

    // Start pulsed while Busy must be dropped
    issue(4'd10, 16'hFFFF, 16'h0003, 16'h1FFF, 4'b0010, 4);
    Start = 1'b1; Function = 4'd1; Op1 = 16'h0001; Op2 = 16'h0001;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();
    chk("ignored_start_result", 32'(Result), 32'h1FFF);

    // Start held high through Done: second op accepted in the Done cycle
    Start = 1'b1; Function = 4'd10; Op1 = 16'h00F0; Op2 = 16'h0002;
    push_exp(16'h003C, 4'b0000, 3);
    @(negedge Clock);
    Function = 4'd1; Op1 = 16'h0010; Op2 = 16'h0020;
    n = 0;
    while (Busy === 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    push_exp(16'h0030, 4'b0000, 1);
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();

    // back-to-back single-cycle ops
    issue(4'd1, 16'h0100, 16'h0200, 16'h0300, 4'b0000, 1);
    issue(4'd1, 16'h4000, 16'h4000, 16'h8000, 4'b0101, 1);
    wait_idle();

    // reset in the middle of an iterative op
`ifdef ALU_MUL_EN
    issue(4'd11, 16'h0123, 16'h0010, 16'h1230, 4'b0000, 17);
`else
    issue(4'd10, 16'hFFFF, 16'h000F, 16'h0001, 4'b0010, 16);
`endif
    repeat (3) @(negedge Clock);
    chk("busy_before_reset", {31'd0, Busy}, 32'd1);
    nReset = 1'b0;
    exp_q.delete();
    iss_q.delete();
    @(negedge Clock);
    chk("midop_reset_result", 32'(Result), 32'd0);
    chk("midop_reset_flags", {28'd0, Zflag, Nflag, Cflag, Vflag}, 32'd0);
    chk("midop_reset_busy_done", {30'd0, Busy, Done}, 32'd0);
    nReset = 1'b1;
    @(negedge Clock);
    issue(4'd1, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 1);
    wait_idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
